mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
MEM-stage access controller that consumes the EX/MEM pipeline register outputs and drives the data-memory port.
- Loads and stores are executed through a req/ack handshake to data memory.
- Non-memory results pass straight through.
- Results are presented to MEM/WB as a registered one-cycle writeback pulse.
- EXtoMEM_Wen is driven back to the EX/MEM register so it holds its contents while an access is outstanding.

Parameters:
ADDR_W, 16, data-memory address width (matches mem_addr)
DATA_W, 32, data width
RADDR_W, 3, destination register address width
TIMEOUT, 255, max ACCESS cycles without dmem_ack before abort; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
ex_valid  input  1  EX/MEM register holds a valid instruction
mem_op_in  input  1  1 = memory access, 0 = ALU result pass-through
store_in  input  1  1 = store, 0 = load (meaningful only when mem_op_in=1)
mem_addr_in  input  ADDR_W  memory address from EX/MEM
rdest_addr_in  input  RADDR_W  destination register from EX/MEM
rdest_data_in  input  DATA_W  ALU result, or store data when store_in=1
EXtoMEM_Wen  output  1  write enable to EX/MEM register; 0 = hold
dmem_req  output  1  memory request
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  ADDR_W  memory address
dmem_wdata  output  DATA_W  write data
dmem_ack  input  1  memory completion, one-cycle pulse
dmem_rdata  input  DATA_W  read data, valid when dmem_ack=1 on a read
wb_valid  output  1  one-cycle writeback pulse to MEM/WB
wb_rdest_addr  output  RADDR_W  writeback register address
wb_rdest_data  output  DATA_W  writeback data
mem_err  output  1  sticky timeout error flag

Behaviour:
- Reset (async, resetn=0): state=IDLE; all registered outputs go to 0 immediately.
  - Registered outputs: dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_rdest_addr, wb_rdest_data, mem_err, timeout counter.
  - An access in progress is dropped without completion; dmem_req falls asynchronously.
  - EXtoMEM_Wen is 1 while in reset.
- States: IDLE, ACCESS.
- IDLE, ex_valid=0:
  - EXtoMEM_Wen=1.
  - wb_valid=0 next cycle.
- IDLE, ex_valid=1, mem_op_in=0 (pass-through):
  - EXtoMEM_Wen=1.
  - Next edge: wb_valid=1, wb_rdest_addr=rdest_addr_in, wb_rdest_data=rdest_data_in.
  - Latency is 1 cycle; back-to-back pass-through ops give wb_valid=1 every cycle.
- IDLE, ex_valid=1, mem_op_in=1 (memory access):
  - EXtoMEM_Wen=0, driven combinationally in the same cycle.
  - Next edge: latch the operation and enter ACCESS.
  - Latched values: dmem_addr=mem_addr_in, dmem_we=store_in, dmem_wdata=rdest_data_in, pending rdest_addr=rdest_addr_in.
  - dmem_req=1 is registered from the transition and is high from the first ACCESS cycle.
  - Timeout counter cleared to 0.
- ACCESS:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata are stable.
  - EXtoMEM_Wen=0 except in the cycle dmem_ack=1, where EXtoMEM_Wen=1 so the EX/MEM register advances.
  - Counter increments each cycle without ack.
- ACCESS, dmem_ack=1:
  - Next edge: dmem_req=0, state=IDLE.
  - Load: wb_valid=1, wb_rdest_addr=pending addr, wb_rdest_data=dmem_rdata.
  - Store: wb_valid=0.
  - Load latency: ack cycle + 1.
- ACCESS timeout (TIMEOUT>0, counter reaches TIMEOUT-1 with no ack):
  - EXtoMEM_Wen=1 that cycle.
  - Next edge: dmem_req=0, mem_err=1, state=IDLE, no wb_valid.
  - mem_err clears only on reset.
- dmem_ack while in IDLE is ignored.
- dmem_ack in the same cycle as the timeout cycle: the ack wins and the access completes normally; no error.
- ex_valid and the other EX/MEM inputs are not sampled in ACCESS.
  - The instruction presented in the ack cycle is sampled in the following IDLE cycle.
  - Every instruction therefore executes exactly once.
- wb_valid is a single-cycle pulse, never held.
- wb_rdest_addr and wb_rdest_data hold their last value when wb_valid=0.

Test Plan:
- Reset: assert resetn=0 mid-ACCESS -> dmem_req, wb_valid, mem_err and wb_rdest_data all 0 immediately; EXtoMEM_Wen=1; state IDLE after release.
- Pass-through: ex_valid=1, mem_op_in=0, rdest_addr_in=3'h5, rdest_data_in=32'hDEADBEEF -> next cycle wb_valid=1, wb_rdest_addr=5, wb_rdest_data=32'hDEADBEEF; EXtoMEM_Wen stays 1.
- Load: mem_op_in=1, store_in=0, mem_addr_in=16'h0040, rdest_addr_in=3'h2; ack after 3 cycles with dmem_rdata=32'h12345678 -> dmem_req high 3 cycles with dmem_addr=16'h0040 and dmem_we=0; EXtoMEM_Wen=0 until the ack cycle; one cycle after ack, wb_valid=1, wb_rdest_addr=2, wb_rdest_data=32'h12345678.
- Store: mem_addr_in=16'h0010, rdest_data_in=32'hA5A5A5A5, store_in=1; ack on the first ACCESS cycle -> dmem_we=1, dmem_wdata=32'hA5A5A5A5; no wb_valid; pass-through op queued behind it gives wb_valid exactly 2 cycles after ack.
- Timeout: TIMEOUT=4, load with no ack -> dmem_req high 4 cycles then 0; mem_err=1 and sticky; no wb_valid; the following pass-through op still completes.
- Back-to-back: load, store, ALU op presented consecutively -> each executes exactly once, in order; EXtoMEM_Wen low only while each memory op waits for ack.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: runs loads/stores over a req/ack data-memory port,
// passes ALU results through, and emits a registered one-cycle writeback pulse.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 3,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ex_valid,
  input  logic               mem_op_in,
  input  logic               store_in,
  input  logic [ADDR_W-1:0]  mem_addr_in,
  input  logic [RADDR_W-1:0] rdest_addr_in,
  input  logic [DATA_W-1:0]  rdest_data_in,
  output logic               EXtoMEM_Wen,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               wb_valid,
  output logic [RADDR_W-1:0] wb_rdest_addr,
  output logic [DATA_W-1:0]  wb_rdest_data,
  output logic               mem_err,
  output logic               dbg_state
);

  // Handshake: dmem_req rises with ACCESS and stays high, with address/data/we
  // stable, until the cycle dmem_ack=1 (or timeout); dmem_ack is ignored in IDLE.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [RADDR_W-1:0] pend_addr_q;
  logic               wb_valid_q;
  logic [RADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic               err_q;
  logic               timeout_hit;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (state_q == ACCESS) && !dmem_ack &&
                           (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Hold EX/MEM while a memory op waits; release it in the ack/timeout cycle.
  assign EXtoMEM_Wen = !resetn ||
                       ((state_q == IDLE) ? !(ex_valid && mem_op_in)
                                          : (dmem_ack || timeout_hit));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pend_addr_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid && mem_op_in) begin
            state_q     <= ACCESS;
            req_q       <= 1'b1;
            we_q        <= store_in;
            addr_q      <= mem_addr_in;
            wdata_q     <= rdest_data_in;
            pend_addr_q <= rdest_addr_in;
            cnt_q       <= '0;
          end else if (ex_valid) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rdest_addr_in;
            wb_data_q  <= rdest_data_in;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            if (!we_q) begin
              wb_valid_q <= 1'b1;
              wb_addr_q  <= pend_addr_q;
              wb_data_q  <= dmem_rdata;
            end
          end else if (timeout_hit) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rdest_addr = wb_addr_q;
  assign wb_rdest_data = wb_data_q;
  assign mem_err       = err_q;
  assign dbg_state     = (state_q == ACCESS);

endmodule
